// File: rtl/mau_pkg.sv
// Shared encodings for the memory-access unit: access sizes, AHB transfer codes,
// error codes and the load FSM state type.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ADDR,
    LD_DATA,
    LD_WB
  } load_state_e;

  // Size 11 is never legal; halves need even and words need 4-byte aligned addresses.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] ea_lo);
    case (size)
      SZ_B:    access_illegal = 1'b0;
      SZ_H:    access_illegal = ea_lo[0];
      SZ_W:    access_illegal = |ea_lo;
      default: access_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Little-endian lane select plus sign/zero extension of a 32-bit AHB read beat.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [1:0]  ea_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] hrdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = hrdata[7:0];
    case (ea_lo)
      2'd1:    byte_lane = hrdata[15:8];
      2'd2:    byte_lane = hrdata[23:16];
      2'd3:    byte_lane = hrdata[31:24];
      default: byte_lane = hrdata[7:0];
    endcase
    half_lane = ea_lo[1] ? hrdata[31:16] : hrdata[15:0];

    case (size)
      SZ_B:    data = {{24{sext & byte_lane[7]}}, byte_lane};
      SZ_H:    data = {{16{sext & half_lane[15]}}, half_lane};
      default: data = hrdata;
    endcase
  end

endmodule

// File: rtl/mau_load_swc.sv
// Load path of the memory-access unit: one AHB-Lite single read per request,
// aligned and extended, written back through a one-cycle register-file port.
module mau_load_swc
  import mau_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255,
  parameter int         ADDR_W  = 32
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              exu_load_en,
  input  logic [4:0]        exu_load_rd,
  input  logic [ADDR_W-1:0] exu_load_base_addr,
  input  logic [ADDR_W-1:0] exu_load_offset,
  input  logic              exu_load_sext,
  input  logic [1:0]        exu_load_size,
  output logic              mau_load_busy,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic              hready,
  input  logic              hresp,
  input  logic [31:0]       hrdata,
  output logic [4:0]        reg_waddr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wen,
  output logic              mau_load_err,
  output logic [1:0]        mau_load_err_code,
  output logic [ADDR_W-1:0] mau_load_err_addr
);

  load_state_e       state_q, state_d;
  logic [4:0]        rd_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] ea_q;
  logic [31:0]       wdata_q;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [ADDR_W-1:0] ea_new;
  logic              accept;
  logic              capture;
  logic [31:0]       load_data;

  assign ea_new = exu_load_base_addr + exu_load_offset;

  mau_load_align u_align (
    .ea_lo  (ea_q[1:0]),
    .size   (size_q),
    .sext   (sext_q),
    .hrdata (hrdata),
    .data   (load_data)
  );

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q    <= LD_IDLE;
      rd_q       <= '0;
      sext_q     <= 1'b0;
      size_q     <= SZ_B;
      ea_q       <= '0;
      wdata_q    <= '0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
      if (accept) begin
        rd_q   <= exu_load_rd;
        sext_q <= exu_load_sext;
        size_q <= exu_load_size;
        ea_q   <= ea_new;
      end
      if (capture) begin
        wdata_q <= load_data;
      end
    end
  end

  // Requests are only looked at in IDLE; errors become a registered one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    accept     = 1'b0;
    capture    = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    err_addr_d = '0;

    case (state_q)
      LD_IDLE: begin
        tmo_cnt_d = '0;
        if (exu_load_en) begin
          if (access_illegal(exu_load_size, ea_new[1:0])) begin
            err_d      = 1'b1;
            err_code_d = ERR_ALIGN;
            err_addr_d = ea_new;
          end else begin
            accept  = 1'b1;
            state_d = LD_ADDR;
          end
        end
      end
      LD_ADDR, LD_DATA: begin
        if (state_q == LD_DATA && hresp) begin
          state_d    = LD_IDLE;
          tmo_cnt_d  = '0;
          err_d      = 1'b1;
          err_code_d = ERR_BUS;
          err_addr_d = ea_q;
        end else if (hready) begin
          tmo_cnt_d = '0;
          if (state_q == LD_ADDR) begin
            state_d = LD_DATA;
          end else begin
            capture = 1'b1;
            state_d = LD_WB;
          end
        end else if (TIMEOUT != 8'd0 && tmo_cnt_q == TIMEOUT - 8'd1) begin
          state_d    = LD_IDLE;
          tmo_cnt_d  = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = ea_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      LD_WB: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign mau_load_busy     = (state_q != LD_IDLE);
  assign haddr             = (state_q == LD_ADDR) ? ea_q : '0;
  assign htrans            = (state_q == LD_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize             = (state_q == LD_ADDR) ? {1'b0, size_q} : 3'b000;
  assign hwrite            = 1'b0;
  assign reg_wen           = (state_q == LD_WB) && (rd_q != 5'd0);
  assign reg_waddr         = (state_q == LD_WB) ? rd_q : 5'd0;
  assign reg_wdata         = (state_q == LD_WB) ? wdata_q : 32'd0;
  assign mau_load_err      = err_q;
  assign mau_load_err_code = err_code_q;
  assign mau_load_err_addr = err_addr_q;

endmodule

// File: tb/tb_mau_load_swc.sv
// Directed self-checking bench for mau_load_swc, built with a 4-cycle timeout.
module tb_mau_load_swc;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        exu_load_en;
  logic [4:0]  exu_load_rd;
  logic [31:0] exu_load_base_addr;
  logic [31:0] exu_load_offset;
  logic        exu_load_sext;
  logic [1:0]  exu_load_size;
  logic        mau_load_busy;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic        mau_load_err;
  logic [1:0]  mau_load_err_code;
  logic [31:0] mau_load_err_addr;

  int total = 0;
  int bad = 0;

  always #5 hclk = ~hclk;

  mau_load_swc #(.TIMEOUT(8'd4), .ADDR_W(32)) dut (
    .hclk               (hclk),
    .hrst               (hrst),
    .exu_load_en        (exu_load_en),
    .exu_load_rd        (exu_load_rd),
    .exu_load_base_addr (exu_load_base_addr),
    .exu_load_offset    (exu_load_offset),
    .exu_load_sext      (exu_load_sext),
    .exu_load_size      (exu_load_size),
    .mau_load_busy      (mau_load_busy),
    .haddr              (haddr),
    .htrans             (htrans),
    .hsize              (hsize),
    .hwrite             (hwrite),
    .hready             (hready),
    .hresp              (hresp),
    .hrdata             (hrdata),
    .reg_waddr          (reg_waddr),
    .reg_wdata          (reg_wdata),
    .reg_wen            (reg_wen),
    .mau_load_err       (mau_load_err),
    .mau_load_err_code  (mau_load_err_code),
    .mau_load_err_addr  (mau_load_err_addr)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] base, input logic [31:0] off,
                       input logic sext, input logic [1:0] size);
    exu_load_en        = 1'b1;
    exu_load_rd        = rd;
    exu_load_base_addr = base;
    exu_load_offset    = off;
    exu_load_sext      = sext;
    exu_load_size      = size;
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    repeat (3) tick();
    hrst = 1'b0;
    tick();
    total++; if (mau_load_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", mau_load_busy); end
    total++; if (htrans !== 2'b00) begin bad++; $display("[TB] FAIL reset_htrans: got %b want 00", htrans); end
    total++; if ({haddr, hsize, hwrite} !== 36'd0) begin bad++; $display("[TB] FAIL reset_bus: got haddr=%h hsize=%b hwrite=%b want all 0", haddr, hsize, hwrite); end
    total++; if ({reg_wen, reg_waddr, reg_wdata} !== 38'd0) begin bad++; $display("[TB] FAIL reset_wb: got wen=%b waddr=%0d wdata=%h want all 0", reg_wen, reg_waddr, reg_wdata); end
    total++; if ({mau_load_err, mau_load_err_code, mau_load_err_addr} !== 35'd0) begin bad++; $display("[TB] FAIL reset_err: got err=%b code=%b addr=%h want all 0", mau_load_err, mau_load_err_code, mau_load_err_addr); end
  endtask

  task automatic test_zero_wait();
    logic [4:0]  v_rd   [5] = '{5'd5, 5'd5, 5'd10, 5'd31, 5'd12};
    logic [31:0] v_base [5] = '{32'h100, 32'h100, 32'h0, 32'h1000, 32'h200};
    logic [31:0] v_off  [5] = '{32'h3, 32'h3, 32'h0, 32'h10, 32'h1};
    logic        v_sext [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  v_size [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [31:0] v_rdat [5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h1234_8001, 32'hDEAD_BEEF, 32'h0000_AB00};
    logic [31:0] v_addr [5] = '{32'h103, 32'h103, 32'h0, 32'h1010, 32'h201};
    logic [31:0] v_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_00AB};
    for (int i = 0; i < 5; i++) begin
      hready = 1'b1;
      issue(v_rd[i], v_base[i], v_off[i], v_sext[i], v_size[i]);
      tick();
      exu_load_en = 1'b0;
      total++; if (haddr !== v_addr[i] || htrans !== 2'b10) begin bad++; $display("[TB] FAIL zw%0d_addr_phase: got haddr=%h htrans=%b want %h 10", i, haddr, htrans, v_addr[i]); end
      total++; if (hsize !== {1'b0, v_size[i]} || mau_load_busy !== 1'b1) begin bad++; $display("[TB] FAIL zw%0d_hsize: got hsize=%b busy=%b want %b 1", i, hsize, mau_load_busy, {1'b0, v_size[i]}); end
      hrdata = v_rdat[i];
      tick();
      total++; if (htrans !== 2'b00 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL zw%0d_data_phase: got htrans=%b wen=%b want 00 0", i, htrans, reg_wen); end
      tick();
      hrdata = 32'h0;
      total++; if (reg_wen !== 1'b1 || reg_waddr !== v_rd[i]) begin bad++; $display("[TB] FAIL zw%0d_wen: got wen=%b waddr=%0d want 1 %0d", i, reg_wen, reg_waddr, v_rd[i]); end
      total++; if (reg_wdata !== v_exp[i]) begin bad++; $display("[TB] FAIL zw%0d_wdata: got %h want %h", i, reg_wdata, v_exp[i]); end
      tick();
      total++; if (reg_wen !== 1'b0 || mau_load_busy !== 1'b0) begin bad++; $display("[TB] FAIL zw%0d_done: got wen=%b busy=%b want 0 0", i, reg_wen, mau_load_busy); end
    end
  endtask

  task automatic test_wait_states();
    hready = 1'b1;
    issue(5'd7, 32'h200, 32'h2, 1'b0, 2'b01);
    tick();
    exu_load_en = 1'b0;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (haddr !== 32'h202 || htrans !== 2'b10 || hsize !== 3'b001) begin bad++; $display("[TB] FAIL ws_addr_hold%0d: got haddr=%h htrans=%b hsize=%b want 202 10 001", i, haddr, htrans, hsize); end
      if (i == 2) hready = 1'b1;
      tick();
    end
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (htrans !== 2'b00 || mau_load_busy !== 1'b1 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL ws_data%0d: got htrans=%b busy=%b wen=%b want 00 1 0", i, htrans, mau_load_busy, reg_wen); end
      if (i == 2) begin hready = 1'b1; hrdata = 32'hBEEF_1234; end
      tick();
    end
    hrdata = 32'h0;
    total++; if (reg_wen !== 1'b1 || reg_waddr !== 5'd7 || reg_wdata !== 32'h0000_BEEF) begin bad++; $display("[TB] FAIL ws_wb: got wen=%b waddr=%0d wdata=%h want 1 7 0000beef", reg_wen, reg_waddr, reg_wdata); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] m_base [2] = '{32'h100, 32'h100};
    logic [31:0] m_off  [2] = '{32'h5, 32'h0};
    logic [1:0]  m_size [2] = '{2'b10, 2'b11};
    logic [31:0] m_addr [2] = '{32'h105, 32'h100};
    hready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(5'd3, m_base[i], m_off[i], 1'b0, m_size[i]);
      tick();
      exu_load_en = 1'b0;
      total++; if (mau_load_err !== 1'b1 || mau_load_err_code !== 2'b01) begin bad++; $display("[TB] FAIL mis%0d_err: got err=%b code=%b want 1 01", i, mau_load_err, mau_load_err_code); end
      total++; if (mau_load_err_addr !== m_addr[i]) begin bad++; $display("[TB] FAIL mis%0d_err_addr: got %h want %h", i, mau_load_err_addr, m_addr[i]); end
      total++; if (htrans !== 2'b00 || mau_load_busy !== 1'b0 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL mis%0d_no_bus: got htrans=%b busy=%b wen=%b want 00 0 0", i, htrans, mau_load_busy, reg_wen); end
      for (int c = 0; c < 3; c++) begin
        tick();
        total++; if (htrans !== 2'b00 || mau_load_err !== 1'b0 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL mis%0d_quiet%0d: got htrans=%b err=%b wen=%b want 00 0 0", i, c, htrans, mau_load_err, reg_wen); end
      end
    end
  endtask

  task automatic test_bus_error();
    hready = 1'b1;
    issue(5'd4, 32'h40, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    tick();
    hresp = 1'b1;
    hready = 1'b0;
    tick();
    total++; if (mau_load_err !== 1'b1 || mau_load_err_code !== 2'b10 || mau_load_err_addr !== 32'h40) begin bad++; $display("[TB] FAIL buserr_pulse: got err=%b code=%b addr=%h want 1 10 00000040", mau_load_err, mau_load_err_code, mau_load_err_addr); end
    total++; if (reg_wen !== 1'b0 || mau_load_busy !== 1'b0) begin bad++; $display("[TB] FAIL buserr_idle: got wen=%b busy=%b want 0 0", reg_wen, mau_load_busy); end
    hresp = 1'b0;
    hready = 1'b1;
    tick();
    total++; if (mau_load_err !== 1'b0 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL buserr_after: got err=%b wen=%b want 0 0", mau_load_err, reg_wen); end
  endtask

  task automatic test_timeout();
    hready = 1'b1;
    issue(5'd2, 32'h80, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    hready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (mau_load_busy !== 1'b1 || htrans !== 2'b10 || mau_load_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_wait%0d: got busy=%b htrans=%b err=%b want 1 10 0", i, mau_load_busy, htrans, mau_load_err); end
      tick();
    end
    total++; if (mau_load_err !== 1'b1 || mau_load_err_code !== 2'b11 || mau_load_err_addr !== 32'h80) begin bad++; $display("[TB] FAIL tmo_pulse: got err=%b code=%b addr=%h want 1 11 00000080", mau_load_err, mau_load_err_code, mau_load_err_addr); end
    total++; if (mau_load_busy !== 1'b0 || htrans !== 2'b00 || reg_wen !== 1'b0) begin bad++; $display("[TB] FAIL tmo_idle: got busy=%b htrans=%b wen=%b want 0 00 0", mau_load_busy, htrans, reg_wen); end
    hready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    hready = 1'b1;
    issue(5'd6, 32'h10, 32'h0, 1'b0, 2'b10);
    tick();
    hready = 1'b0;
    issue(5'd1, 32'h33, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    total++; if (haddr !== 32'h10 || mau_load_err !== 1'b0) begin bad++; $display("[TB] FAIL busy_ignore_addr: got haddr=%h err=%b want 00000010 0", haddr, mau_load_err); end
    hready = 1'b1;
    tick();
    hrdata = 32'h1234_5678;
    total++; if (mau_load_err !== 1'b0 || htrans !== 2'b00) begin bad++; $display("[TB] FAIL busy_ignore_data: got err=%b htrans=%b want 0 00", mau_load_err, htrans); end
    tick();
    hrdata = 32'h0;
    total++; if (reg_wen !== 1'b1 || reg_waddr !== 5'd6 || reg_wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL busy_ignore_wb: got wen=%b waddr=%0d wdata=%h want 1 6 12345678", reg_wen, reg_waddr, reg_wdata); end
    issue(5'd1, 32'h101, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    total++; if (mau_load_busy !== 1'b0 || mau_load_err !== 1'b0) begin bad++; $display("[TB] FAIL wb_en_ignored: got busy=%b err=%b want 0 0", mau_load_busy, mau_load_err); end
    tick();
    total++; if (mau_load_busy !== 1'b0 || mau_load_err !== 1'b0 || htrans !== 2'b00) begin bad++; $display("[TB] FAIL wb_en_later: got busy=%b err=%b htrans=%b want 0 0 00", mau_load_busy, mau_load_err, htrans); end
  endtask

  task automatic test_wrap();
    hready = 1'b1;
    issue(5'd9, 32'h4, 32'hFFFF_FFFC, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    total++; if (haddr !== 32'h0 || htrans !== 2'b10) begin bad++; $display("[TB] FAIL wrap_haddr: got haddr=%h htrans=%b want 00000000 10", haddr, htrans); end
    hrdata = 32'hCAFE_F00D;
    tick();
    tick();
    hrdata = 32'h0;
    total++; if (reg_wen !== 1'b1 || reg_wdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL wrap_wb: got wen=%b wdata=%h want 1 cafef00d", reg_wen, reg_wdata); end
    tick();
  endtask

  task automatic test_rd_zero();
    hready = 1'b1;
    issue(5'd0, 32'h20, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    total++; if (haddr !== 32'h20 || htrans !== 2'b10) begin bad++; $display("[TB] FAIL rd0_bus: got haddr=%h htrans=%b want 00000020 10", haddr, htrans); end
    hrdata = 32'h1111_1111;
    tick();
    tick();
    total++; if (reg_wen !== 1'b0 || mau_load_busy !== 1'b1) begin bad++; $display("[TB] FAIL rd0_wb: got wen=%b busy=%b want 0 1", reg_wen, mau_load_busy); end
    tick();
    total++; if (reg_wen !== 1'b0 || mau_load_busy !== 1'b0) begin bad++; $display("[TB] FAIL rd0_done: got wen=%b busy=%b want 0 0", reg_wen, mau_load_busy); end
  endtask

  task automatic test_reset_mid();
    hready = 1'b1;
    issue(5'd8, 32'h30, 32'h0, 1'b0, 2'b10);
    tick();
    exu_load_en = 1'b0;
    tick();
    hrst = 1'b1;
    hrdata = 32'h55AA_55AA;
    tick();
    total++; if (mau_load_busy !== 1'b0 || reg_wen !== 1'b0 || mau_load_err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_idle: got busy=%b wen=%b err=%b want 0 0 0", mau_load_busy, reg_wen, mau_load_err); end
    hrst = 1'b0;
    tick();
    hrdata = 32'h0;
    total++; if (mau_load_busy !== 1'b0 || reg_wen !== 1'b0 || mau_load_err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_after: got busy=%b wen=%b err=%b want 0 0 0", mau_load_busy, reg_wen, mau_load_err); end
  endtask

  initial begin
    hrst               = 1'b1;
    exu_load_en        = 1'b0;
    exu_load_rd        = 5'd0;
    exu_load_base_addr = 32'h0;
    exu_load_offset    = 32'h0;
    exu_load_sext      = 1'b0;
    exu_load_size      = 2'b00;
    hready             = 1'b1;
    hresp              = 1'b0;
    hrdata             = 32'h0;
    $display("[TB] starting mau_load_swc directed tests");
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_rd_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mau_load_swc.md
Name: mau_load_swc

Overview:
- Memory-access-unit load path. Consumes the load request issued by the execute-stage load unit: rd, base, offset, sext, size and enable.
- Performs one AHB-Lite single read and aligns / sign- or zero-extends the returned data.
- Writes the result back to the register file through a one-cycle write port.
- Sits between the EXU load stage and the core's AHB-Lite data master port; busy back-pressures the core stall logic.

Parameters:
- TIMEOUT, 8'd255: max consecutive hready-low cycles in any bus phase before a timeout error is raised; 0 disables the timeout.
- ADDR_W, 32: address width; data width is fixed at 32.

Ports:
- hclk  in  1  core clock
- hrst  in  1  reset; one clock; reset is synchronous and active-high
- exu_load_en  in  1  request strobe, one cycle
- exu_load_rd  in  5  destination register
- exu_load_base_addr  in  32  base address (rs1 value)
- exu_load_offset  in  32  sign-extended immediate
- exu_load_sext  in  1  1 = sign-extend, 0 = zero-extend
- exu_load_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- mau_load_busy  out  1  high in every non-IDLE state
- haddr  out  32  AHB address
- htrans  out  2  00 = IDLE, 10 = NONSEQ
- hsize  out  3  {1'b0, size}
- hwrite  out  1  tied 0
- hready  in  1  AHB ready
- hresp  in  1  AHB error response
- hrdata  in  32  AHB read data
- reg_waddr  out  5  writeback register
- reg_wdata  out  32  writeback data
- reg_wen  out  1  writeback strobe
- mau_load_err  out  1  one-cycle error pulse
- mau_load_err_code  out  2  01 = misaligned / illegal size, 10 = bus error, 11 = timeout
- mau_load_err_addr  out  32  faulting effective address

Behaviour:
- Reset (hrst = 1 at a hclk edge): state IDLE; all outputs 0; htrans = IDLE; timeout counter 0.
- Reset mid-transfer: FSM returns to IDLE at that edge; any outstanding data phase is discarded; no writeback; no error.
- States: IDLE, ADDR, DATA, WB.
- IDLE: when exu_load_en = 1, latch rd, sext, size and ea = base + offset (32-bit, carry discarded, wraps).
  - Alignment check: half needs ea[0] = 0; word needs ea[1:0] = 00; size 11 is illegal.
  - Fail: stay IDLE, no bus access, next cycle pulse mau_load_err with code 01 and err_addr = ea.
  - Pass: go to ADDR.
- ADDR: drive haddr = ea, htrans = NONSEQ, hsize.
  - hready = 1: go to DATA.
  - hready = 0: hold all address-phase signals stable.
- DATA: htrans = IDLE.
  - hready = 1 and hresp = 0: capture and align hrdata, go to WB.
  - hresp = 1: on the first hresp cycle go to IDLE with no writeback; err pulse code 10.
- WB: reg_wen = 1 for exactly one cycle, then IDLE.
  - rd = 0: reg_wen stays 0 but the access still completes.
- Data alignment, little-endian:
  - Byte = hrdata[8*ea[1:0] +: 8].
  - Half = hrdata[16*ea[1] +: 16].
  - Extend to 32 bits per sext.
  - Word passes through unchanged.
- Latency, zero wait states: request at cycle N; ADDR at N+1; DATA at N+2; reg_wen at N+3. Each hready-low cycle adds one.
- Timeout: a counter increments on each hready-low cycle in ADDR or DATA and clears when hready = 1.
  - Reaching TIMEOUT: go to IDLE, htrans = IDLE, err pulse code 11.
- exu_load_en while busy: ignored, no state change. The issuer stalls on mau_load_busy.
- exu_load_en in the same cycle the FSM returns to IDLE: not accepted; it is accepted only when the current state is IDLE.
- mau_load_err and reg_wen are never high together.

Decomposition:
- Shared package mau_pkg:
  - size encodings (SZ_B / SZ_H / SZ_W);
  - HTRANS codes;
  - error codes;
  - FSM state enum.
- Sub-module mau_load_align: combinational lane select plus sign/zero extension (inputs ea[1:0], size, sext, hrdata). Reused later by the store/AMO path.

Test Plan:
- Reset: hold hrst 3 cycles, then release → all outputs 0, busy = 0, htrans = 00.
- Zero-wait lb: base 0x100, offset 0x3, hrdata 0x80FF_0000 → haddr 0x103, hsize 000; reg_wdata 0xFFFF_FF80 at N+3; with sext = 0 (lbu) → 0x0000_0080.
- lhu with 2 wait states each in the address and data phases: ea 0x202, hrdata 0xBEEF_1234 → reg_wdata 0x0000_BEEF at N+7, haddr stable while hready = 0.
- Misaligned lw at ea 0x105 → no NONSEQ ever driven; err = 1, code 01, err_addr 0x105; no reg_wen.
- hresp = 1 in the data phase → err code 10, no reg_wen. TIMEOUT = 4 with hready stuck low → err code 11 after 4 cycles, FSM IDLE.
- Pulse exu_load_en while busy → ignored. Offset 0xFFFF_FFFC with base 0x4 → ea wraps to 0x0. rd = 0 → bus access occurs, reg_wen never asserted. hrst asserted in DATA → IDLE next cycle, no writeback.
